// File: rtl/fetch_queue.sv
// fetch_queue
//   Dual-issue instruction buffer sitting between fetch and decode. Fetch pushes
//   up to two instructions per cycle into a circular queue; decode sees the two
//   oldest entries as an in-order pair and consumes 0, 1 or 2 of them per cycle.
//   A flush (redirect) empties the queue and drops any same-cycle push.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   fetch_valid_i  [1:0] per-slot valid of the fetch bundle
//   fetch_inst0_i  instruction at fetch_pc_i
//   fetch_inst1_i  instruction at fetch_pc_i+4
//   fetch_pc_i     PC of slot 0
//   fetch_ready_o  queue has room for a full two-wide bundle
//   stall_i        decode cannot consume this cycle
//   flush_i        discard everything, including this cycle's push
//   inst0_o/pc0_o  oldest entry (NOP / 0 when invalid)
//   inst1_o/pc1_o  second-oldest entry (NOP / 0 when invalid)
//   valid0_o/valid1_o  output slot valids
//   count_o        number of occupied entries
module fetch_queue #(
   parameter int          DEPTH = 8,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [1:0]               fetch_valid_i,
   input  logic [31:0]              fetch_inst0_i,
   input  logic [31:0]              fetch_inst1_i,
   input  logic [31:0]              fetch_pc_i,
   output logic                     fetch_ready_o,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic [31:0]              inst0_o,
   output logic [31:0]              inst1_o,
   output logic [31:0]              pc0_o,
   output logic [31:0]              pc1_o,
   output logic                     valid0_o,
   output logic                     valid1_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW        = $clog2(DEPTH);
   localparam int CW        = PW + 1;
   localparam int NUM_LANES = 2;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;

   logic          accept;
   logic [1:0]    push_n, pop_n;
   entry_t        wdata0, wdata1;

   logic [NUM_LANES-1:0] slot_valid;
   entry_t               slot [NUM_LANES];

   // Ready depends only on registered occupancy, so fetch never sees a
   // combinational path from stall_i. Two free entries are always required,
   // so a lone-slot bundle is refused at DEPTH-1 as well.
   assign fetch_ready_o = (count <= CW'(DEPTH - 2));
   assign accept        = fetch_ready_o & ~flush_i;

   // Compaction: a bundle with only slot 1 valid lands at wr_ptr with pc+4.
   always_comb begin
      wdata0 = '{inst: fetch_inst0_i, pc: fetch_pc_i};
      wdata1 = '{inst: fetch_inst1_i, pc: fetch_pc_i + 32'd4};
      if (fetch_valid_i == 2'b10) wdata0 = wdata1;
   end

   always_comb begin
      push_n = 2'd0;
      if (accept) push_n = {1'b0, fetch_valid_i[0]} + {1'b0, fetch_valid_i[1]};
   end

   // Decode takes whatever is valid; slot 1 is never valid without slot 0,
   // so consumption is always in program order.
   always_comb begin
      pop_n = 2'd0;
      if (!stall_i && !flush_i) pop_n = {1'b0, slot_valid[0]} + {1'b0, slot_valid[1]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop_n);
         wr_ptr <= wr_ptr + PW'(push_n);
         count  <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (accept && fetch_valid_i != 2'b00) mem[wr_ptr] <= wdata0;
      if (accept && fetch_valid_i == 2'b11) mem[wr_ptr + PW'(1)] <= wdata1;
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx           = rd_ptr + PW'(l);
      assign slot_valid[l] = (count > CW'(l));
      assign slot[l]       = slot_valid[l] ? mem[idx] : entry_t'{NOP, 32'h0};
   end

   assign valid0_o = slot_valid[0];
   assign valid1_o = slot_valid[1];
   assign inst0_o  = slot[0].inst;
   assign pc0_o    = slot[0].pc;
   assign inst1_o  = slot[1].inst;
   assign pc1_o    = slot[1].pc;
   assign count_o  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=8). A queue-based model tracks the
//   expected contents in program order; one negedge process compares every
//   output against it, and the directed sequences add literal expectations.
module tb_fetch_queue;

   localparam int          DEPTH = 8;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  fv = 2'b00;
   logic [31:0] fi0 = '0, fi1 = '0, fpc = '0;
   logic        ready;
   logic        stall = 1'b0, flush = 1'b0;
   logic [31:0] inst0, inst1, pc0, pc1;
   logic        v0, v1;
   logic [3:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .fetch_valid_i(fv), .fetch_inst0_i(fi0), .fetch_inst1_i(fi1), .fetch_pc_i(fpc),
      .fetch_ready_o(ready), .stall_i(stall), .flush_i(flush),
      .inst0_o(inst0), .inst1_o(inst1), .pc0_o(pc0), .pc1_o(pc1),
      .valid0_o(v0), .valid1_o(v1), .count_o(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pop what decode sees, then append the accepted bundle in order.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         mq.delete();
      end else begin
         int sz;
         bit rdy;
         sz  = mq.size();
         rdy = (sz <= DEPTH - 2);
         if (!stall) begin
            for (int k = 0; k < 2 && k < sz; k++) void'(mq.pop_front());
         end
         if (rdy) begin
            if (fv[0]) mq.push_back('{fi0, fpc});
            if (fv[1]) mq.push_back('{fi1, fpc + 32'd4});
         end
      end
   end

   always @(negedge clk) begin
      int sz;
      sz = mq.size();
      chk("count", 32'(count), 32'(sz));
      chk("ready", 32'(ready), 32'(sz <= DEPTH - 2));
      chk("valid0", 32'(v0), 32'(sz >= 1));
      chk("valid1", 32'(v1), 32'(sz >= 2));
      chk("inst0", inst0, (sz >= 1) ? mq[0].inst : NOP);
      chk("pc0",   pc0,   (sz >= 1) ? mq[0].pc   : 32'h0);
      chk("inst1", inst1, (sz >= 2) ? mq[1].inst : NOP);
      chk("pc1",   pc1,   (sz >= 2) ? mq[1].pc   : 32'h0);
   end

   task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic st, input logic fl);
      @(negedge clk);
      #1;
      fv = v; fi0 = a; fi1 = b; fpc = pc; stall = st; flush = fl;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_inst0", inst0, NOP);
      chk("rst_inst1", inst1, NOP);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Pair flow
      drive(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 32'h100, 1'b0, 1'b0);
      after_edge();
      chk("pair_inst0", inst0, 32'hAAAA_0001);
      chk("pair_pc0",   pc0,   32'h100);
      chk("pair_inst1", inst1, 32'hBBBB_0002);
      chk("pair_pc1",   pc1,   32'h104);
      chk("pair_v1",    32'(v1), 32'd1);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      after_edge();
      chk("pair_drained", 32'(count), 32'd0);

      // Partial bundles
      drive(2'b10, 32'hDEAD_DEAD, 32'hCCCC_0003, 32'h200, 1'b1, 1'b0);
      after_edge();
      chk("part_inst0", inst0, 32'hCCCC_0003);
      chk("part_pc0",   pc0,   32'h204);
      chk("part_v1",    32'(v1), 32'd0);
      drive(2'b01, 32'hDDDD_0004, 32'hDEAD_DEAD, 32'h208, 1'b1, 1'b0);
      after_edge();
      chk("part_inst1", inst1, 32'hDDDD_0004);
      chk("part_pc1",   pc1,   32'h208);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      after_edge();
      chk("part_drained", 32'(count), 32'd0);

      // Fill under stall: 2,4,6,8 then bundles dropped
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, 32'h1000 + 32'(2*k), 32'h1001 + 32'(2*k), 32'h300 + 32'(8*k), 1'b1, 1'b0);
         after_edge();
         chk("fill_count", 32'(count), (k < 4) ? 32'(2*k + 2) : 32'd8);
      end
      chk("fill_ready", 32'(ready), 32'd0);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      after_edge();
      chk("drain_inst0", inst0, 32'h1002);
      chk("drain_pc0",   pc0,   32'h308);
      repeat (3) after_edge();
      chk("drain_empty", 32'(count), 32'd0);

      // Count 7 also blocks fetch
      drive(2'b11, 32'h2000, 32'h2001, 32'h400, 1'b1, 1'b0);
      drive(2'b11, 32'h2002, 32'h2003, 32'h408, 1'b1, 1'b0);
      drive(2'b11, 32'h2004, 32'h2005, 32'h410, 1'b1, 1'b0);
      drive(2'b01, 32'h2006, 32'h0,    32'h418, 1'b1, 1'b0);
      after_edge();
      chk("seven_count", 32'(count), 32'd7);
      chk("seven_ready", 32'(ready), 32'd0);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      after_edge();
      chk("five_count", 32'(count), 32'd5);

      // Flush with same-cycle push at count 5
      drive(2'b00, 0, 0, 0, 1'b1, 1'b0);
      drive(2'b11, 32'h3000, 32'h3001, 32'h500, 1'b0, 1'b1);
      after_edge();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_v0",    32'(v0), 32'd0);
      chk("flush_inst0", inst0, NOP);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      after_edge();
      chk("flush_stays", 32'(count), 32'd0);

      // Mixed traffic across pointer wrap, including pc+4 wrap
      for (int k = 0; k < 40; k++) begin
         logic [31:0] pc;
         pc = (k == 17) ? 32'hFFFF_FFFC : 32'h8000 + 32'(8*k);
         drive(2'($urandom_range(0, 3)), $urandom, $urandom, pc,
               1'($urandom_range(0, 2) == 0), 1'b0);
      end

      // Mid-stream async reset
      drive(2'b11, 32'h4000, 32'h4001, 32'h600, 1'b1, 1'b0);
      drive(2'b11, 32'h4002, 32'h4003, 32'h608, 1'b1, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("amid_count", 32'(count), 32'd0);
      chk("amid_v0",    32'(v0), 32'd0);
      chk("amid_inst1", inst1, NOP);
      chk("amid_ready", 32'(ready), 32'd1);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(2'b01, 32'h5000, 32'h0, 32'h700, 1'b0, 1'b0);
      after_edge();
      chk("post_rst_inst0", inst0, 32'h5000);
      chk("post_rst_count", 32'(count), 32'd1);
      drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
